stream_header_parser: RTL
=========================

Name: stream_header_parser

Overview:
- Parametrised successor to the single-word packet parser.
- Accepts packets as a valid/ready beat stream of DATA_W bits and captures the first HDR_BYTES of each packet.
- Decodes Ethernet (optional 802.1Q tag), IPv4 with variable IHL, and TCP/UDP ports, then presents one metadata record per packet on a valid/ready output.
- Sits between the MAC receive stream and the flow classifier.

Parameters:
DATA_W, 32, input beat width in bits; multiple of 8, 32..256
HDR_BYTES, 96, header capture depth in bytes; must be >= 42
CNT_W, 32, width of packet/error statistics counters

Ports:
CLK  input  1  clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  beat valid
in_ready  output  1  beat accepted when in_valid && in_ready
in_data  input  DATA_W  packet byte 0 of beat on in_data[DATA_W-1:DATA_W-8] (big-endian lanes)
in_sop  input  1  first beat of packet
in_eop  input  1  last beat of packet
in_eop_bytes  input  $clog2(DATA_W/8)+1  valid bytes in eop beat, 1..DATA_W/8; ignored otherwise
meta_valid  output  1  metadata record valid
meta_ready  input  1  record consumed when meta_valid && meta_ready
meta  output  $bits(parser_meta_t)  dst_mac, src_mac, ethertype, vlan_present, vlan_id[11:0], ip_src, ip_dst, ip_proto, l4_src, l4_dst, pkt_class, err[2:0], pkt_len[15:0]
stat_pkts  output  CNT_W  records emitted
stat_errs  output  CNT_W  records emitted with err != 0
stat_drops  output  CNT_W  packets aborted by an unexpected sop

Behaviour:
- Reset: state IDLE, in_ready=0 during reset then 1 in IDLE, meta_valid=0, meta=0, all stat counters 0, byte count 0. Reset mid-packet discards the packet and any pending record.
- States:
  - IDLE: in_ready=1. Accepted beat without sop is discarded. Beat with sop: bytes written to buffer at 0.., byte_cnt = beat bytes; then CAPTURE, or PARSE if eop on the same beat.
  - CAPTURE: in_ready=1. Each accepted beat writes only lanes whose absolute offset < HDR_BYTES. byte_cnt += beat bytes (in_eop_bytes on eop), saturating at 16'hFFFF.
    - eop goes to PARSE.
    - sop on an accepted beat: stat_drops++, restart capture with this beat as byte 0.
  - PARSE: exactly one cycle, in_ready=0. Fields are decoded from the buffer and byte_cnt into the meta register. Then META.
  - META: meta_valid=1, in_ready=0. meta stays stable until meta_ready. Handshake cycle: meta_valid falls next cycle, stat_pkts++ and stat_errs++ if err!=0, then IDLE.
- Minimum turnaround: eop accept at cycle N; meta_valid at N+2; in_ready back at the cycle after the meta handshake.
- Decode rules (offsets in bytes):
  - dst 0..5, src 6..11, T = 12..13.
  - T==16'h8100: vlan_present=1, vlan_id = bytes 14..15 [11:0], ethertype = 16..17, L3 = 18. Otherwise ethertype = T, L3 = 14.
  - ethertype==16'h0800:
    - version = L3[7:4], IHL = L3[3:0], proto at L3+9, src at L3+12, dst at L3+16.
    - L4 = L3 + 4*IHL; ports at L4+0 and L4+2 when proto is 6 or 17.
  - pkt_class: NON_IP, IPV4_OTHER, IPV4_TCP, IPV4_UDP.
  - Fields not applicable to the class are reported as 0.
  - Port fields are also 0 when err is nonzero.
- err bits:
  - [0] TRUNC: byte_cnt < last byte required by the decoded class. Required end is 14/18 for NON_IP, L3+20 for IPv4, L4+4 for TCP/UDP.
  - [1] BAD_IP: version != 4 or IHL < 5; class forced to IPV4_OTHER.
  - [2] HDR_OVF: required end > HDR_BYTES.
- pkt_len = byte_cnt.
- Counters wrap at 2^CNT_W.

Decomposition:
- parser_pkg holds:
  - parser_meta_t packed struct
  - pkt_class_e enum
  - constants ETHERTYPE_IPV4=16'h0800, ETHERTYPE_VLAN=16'h8100, PROTO_TCP=8'h06, PROTO_UDP=8'h11
  - err bit indices
- One combinational sub-module, hdr_field_decode: takes the buffer and byte_cnt, returns parser_meta_t.
- The top holds the FSM, capture buffer, handshakes and counters.

Test Plan:
- DATA_W=32, 64-byte untagged TCP frame, IHL=5, ports 0x1234->0x0050, meta_ready=1 -> one record with pkt_class=IPV4_TCP, l4_src=16'h1234, l4_dst=16'h0050, err=0, pkt_len=64, meta_valid exactly 2 cycles after the eop beat.
- DATA_W=64, VLAN-tagged UDP frame, vlan_id=12'h00A, IHL=6 -> vlan_present=1, ethertype=16'h0800, ports read from offset 42, pkt_class=IPV4_UDP.
- 30-byte frame, ethertype 0x0800, in_eop_bytes=6 on the last beat -> err[0]=1, pkt_len=30, ports=0, stat_errs=1.
- Hold meta_ready=0 for 10 cycles, then a second packet offered -> in_ready stays 0, meta stable; after the handshake the second packet is parsed intact.
- sop arriving mid-CAPTURE -> stat_drops=1; only the second packet yields a record.
- Assert reset during CAPTURE and again during META -> all outputs 0 next cycle, no record, counters 0.

Source files
------------

// File: rtl/stream_header_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parser_pkg
// Description : Shared types and constants for the stream header parser.
// Revision    : 1.0 - initial release
// ============================================================================
package parser_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
  localparam logic [7:0]  PROTO_TCP      = 8'h06;
  localparam logic [7:0]  PROTO_UDP      = 8'h11;

  // Bit positions inside the err field
  localparam int ERR_TRUNC   = 0;
  localparam int ERR_BAD_IP  = 1;
  localparam int ERR_HDR_OVF = 2;

  typedef enum logic [1:0] {
    NON_IP     = 2'd0,
    IPV4_OTHER = 2'd1,
    IPV4_TCP   = 2'd2,
    IPV4_UDP   = 2'd3
  } pkt_class_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_PARSE   = 2'd2,
    S_META    = 2'd3
  } parser_state_e;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        vlan_present;
    logic [11:0] vlan_id;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [7:0]  ip_proto;
    logic [15:0] l4_src;
    logic [15:0] l4_dst;
    pkt_class_e  pkt_class;
    logic [2:0]  err;
    logic [15:0] pkt_len;
  } parser_meta_t;

endpackage
`default_nettype wire

// File: rtl/stream_header_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_header_parser_if
// Description : Beat input stream and metadata output stream of the parser.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_header_parser_if #(
  parameter int DATA_W = 32
);
  import parser_pkg::*;

  localparam int EB_W = $clog2(DATA_W/8) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic [EB_W-1:0]   in_eop_bytes;
  logic              meta_valid;
  logic              meta_ready;
  parser_meta_t      meta;

  // Parser side
  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_eop_bytes, meta_ready,
    output in_ready, meta_valid, meta
  );

  // Source / sink side
  modport master (
    output in_valid, in_data, in_sop, in_eop, in_eop_bytes, meta_ready,
    input  in_ready, meta_valid, meta
  );

endinterface
`default_nettype wire

// File: rtl/stream_header_parser_decode.sv
`default_nettype none
// ============================================================================
// Module      : hdr_field_decode
// Description : Combinational Ethernet/VLAN/IPv4/L4 decode of a captured header.
// Revision    : 1.0 - initial release
// ============================================================================
module hdr_field_decode
  import parser_pkg::*;
#(
  parameter int HDR_BYTES = 96
) (
  input  logic [8*HDR_BYTES-1:0] hdr_i,      // byte i at [8*i +: 8]
  input  logic [15:0]            byte_cnt_i,
  output parser_meta_t           meta_o
);

  // Bytes past the capture depth read as zero; HDR_OVF flags that case
  function automatic logic [7:0] hb(input logic [8*HDR_BYTES-1:0] h, input logic [15:0] idx);
    hb = 8'h00;
    if (int'(idx) < HDR_BYTES) hb = h[int'(idx)*8 +: 8];
  endfunction

  logic [15:0] type_w, vid_w, l3_w, l4_w, req_end_w;
  logic [7:0]  vihl_w;
  logic [2:0]  err_w;
  pkt_class_e  cls_w;
  parser_meta_t m_w;

  // Walk L2 -> L3 -> L4 and compute the byte count each class needs
  always_comb begin
    m_w       = '0;
    err_w     = '0;
    cls_w     = NON_IP;
    vihl_w    = '0;
    l4_w      = '0;
    type_w    = {hb(hdr_i, 16'd12), hb(hdr_i, 16'd13)};
    vid_w     = {hb(hdr_i, 16'd14), hb(hdr_i, 16'd15)};
    for (int i = 0; i < 6; i++) begin
      m_w.dst_mac[47-8*i -: 8] = hb(hdr_i, 16'(i));
      m_w.src_mac[47-8*i -: 8] = hb(hdr_i, 16'(6 + i));
    end
    if (type_w == ETHERTYPE_VLAN) begin
      m_w.vlan_present = 1'b1;
      m_w.vlan_id      = vid_w[11:0];
      m_w.ethertype    = {hb(hdr_i, 16'd16), hb(hdr_i, 16'd17)};
      l3_w             = 16'd18;
    end else begin
      m_w.ethertype    = type_w;
      l3_w             = 16'd14;
    end
    req_end_w = l3_w;
    if (m_w.ethertype == ETHERTYPE_IPV4) begin
      cls_w          = IPV4_OTHER;
      vihl_w         = hb(hdr_i, l3_w);
      m_w.ip_proto   = hb(hdr_i, l3_w + 16'd9);
      for (int i = 0; i < 4; i++) begin
        m_w.ip_src[31-8*i -: 8] = hb(hdr_i, l3_w + 16'(12 + i));
        m_w.ip_dst[31-8*i -: 8] = hb(hdr_i, l3_w + 16'(16 + i));
      end
      req_end_w = l3_w + 16'd20;
      if (vihl_w[7:4] != 4'd4 || vihl_w[3:0] < 4'd5) begin
        err_w[ERR_BAD_IP] = 1'b1;
      end else if (m_w.ip_proto == PROTO_TCP || m_w.ip_proto == PROTO_UDP) begin
        cls_w      = (m_w.ip_proto == PROTO_TCP) ? IPV4_TCP : IPV4_UDP;
        l4_w       = l3_w + {10'd0, vihl_w[3:0], 2'b00};
        req_end_w  = l4_w + 16'd4;
        m_w.l4_src = {hb(hdr_i, l4_w), hb(hdr_i, l4_w + 16'd1)};
        m_w.l4_dst = {hb(hdr_i, l4_w + 16'd2), hb(hdr_i, l4_w + 16'd3)};
      end
    end
    err_w[ERR_TRUNC]   = (byte_cnt_i < req_end_w);
    err_w[ERR_HDR_OVF] = (int'(req_end_w) > HDR_BYTES);
    if (err_w != 3'b000) begin
      m_w.l4_src = '0;
      m_w.l4_dst = '0;
    end
    m_w.pkt_class = cls_w;
    m_w.err       = err_w;
    m_w.pkt_len   = byte_cnt_i;
    meta_o        = m_w;
  end

endmodule
`default_nettype wire

// File: rtl/stream_header_parser.sv
`default_nettype none
// ============================================================================
// Module      : stream_header_parser
// Description : Captures packet headers from a beat stream and emits one
//               decoded metadata record per packet, with statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_header_parser
  import parser_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int HDR_BYTES = 96,
  parameter int CNT_W     = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  stream_header_parser_if.slave bus,
  output logic [CNT_W-1:0]     stat_pkts,
  output logic [CNT_W-1:0]     stat_errs,
  output logic [CNT_W-1:0]     stat_drops
);

  localparam int NB = DATA_W / 8;

  parser_state_e          state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  parser_meta_t           meta_q, meta_d, dec_meta;
  logic [CNT_W-1:0]       pkts_q, pkts_d, errs_q, errs_d, drops_q, drops_d;
  logic [8*HDR_BYTES-1:0] buf_q;
  logic                   wr_en;
  logic [15:0]            wr_base;
  logic [15:0]            beat_bytes;
  logic [16:0]            sum;
  logic                   in_ready, acc;

  // Ready only while collecting beats and never while reset is asserted
  assign in_ready       = !reset && (state_q == S_IDLE || state_q == S_CAPTURE);
  assign acc            = bus.in_valid && in_ready;
  assign beat_bytes     = bus.in_eop ? 16'(bus.in_eop_bytes) : 16'(NB);
  assign sum            = {1'b0, cnt_q} + {1'b0, beat_bytes};
  assign bus.in_ready   = in_ready;
  assign bus.meta_valid = (state_q == S_META);
  assign bus.meta       = meta_q;
  assign stat_pkts      = pkts_q;
  assign stat_errs      = errs_q;
  assign stat_drops     = drops_q;

  hdr_field_decode #(.HDR_BYTES(HDR_BYTES)) u_decode (
    .hdr_i      (buf_q),
    .byte_cnt_i (cnt_q),
    .meta_o     (dec_meta)
  );

  // Next-state, byte count, record and counter updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    meta_d  = meta_q;
    pkts_d  = pkts_q;
    errs_d  = errs_q;
    drops_d = drops_q;
    wr_en   = 1'b0;
    wr_base = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc && bus.in_sop) begin
          wr_en   = 1'b1;
          wr_base = '0;
          cnt_d   = beat_bytes;
          state_d = bus.in_eop ? S_PARSE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (acc) begin
          wr_en = 1'b1;
          if (bus.in_sop) begin
            // New packet started before eop: abandon the old one
            drops_d = drops_q + 1'b1;
            wr_base = '0;
            cnt_d   = beat_bytes;
          end else begin
            cnt_d   = sum[16] ? 16'hFFFF : sum[15:0];
          end
          state_d = bus.in_eop ? S_PARSE : S_CAPTURE;
        end
      end
      S_PARSE: begin
        meta_d  = dec_meta;
        state_d = S_META;
      end
      S_META: begin
        if (bus.meta_ready) begin
          pkts_d  = pkts_q + 1'b1;
          if (meta_q.err != 3'b000) errs_d = errs_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, record and statistics registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      meta_q  <= '0;
      pkts_q  <= '0;
      errs_q  <= '0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      meta_q  <= meta_d;
      pkts_q  <= pkts_d;
      errs_q  <= errs_d;
      drops_q <= drops_d;
    end
  end

  // Header capture: valid lanes that land inside the capture window
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (k < int'(beat_bytes) && (int'(wr_base) + k) < HDR_BYTES) begin
          buf_q[(int'(wr_base) + k)*8 +: 8] <= bus.in_data[DATA_W-1-8*k -: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
